cntclk_sched: RTL and testbench
===============================

Name: cntclk_sched

Overview:
- Scheduler that shares one cntclk loadable down-counter among NREQ requesters.
- Each requester asks for a delay in clk cycles. The scheduler arbitrates round-robin, loads the counter with the granted delay, waits for the counter's zero flag, then pulses done to that requester.
- Sits between requester logic and the cntclk instance. The top level turns cnt_load/cnt_value into the counter's shared load bus (bus driven only while cnt_load=1).

Parameters:
- WIDTH, 16, counter / delay width.
- NREQ, 4, number of requesters (2..8).
- WDOG_MARGIN, 16, extra cycles allowed past the delay before the watchdog fires (only with the optional feature).

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NREQ  per-requester level request; held until done.
- req_delay  input  NREQ*WIDTH  per-requester delay; slice i = bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, held from LOAD through DONE.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- cnt_load  output  1  one-cycle load strobe to the counter.
- cnt_value  output  WIDTH  load value; valid while cnt_load=1, else 0.
- cnt_zero  input  1  zero flag from the counter.
- err  output  1  watchdog error pulse (tied 0 without the optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; gnt, done, cnt_load, cnt_value, err, busy all 0; round-robin pointer = 0. Reset mid-operation aborts immediately: no done pulse; the counter is left running.
- States: IDLE, LOAD, ARM, WAIT, DONE.
- IDLE: if any req bit is set, choose the first set bit at or above the pointer, wrapping modulo NREQ. Latch its index and its req_delay into dly_q. Go to LOAD.
- LOAD: gnt[idx]=1.
  - If dly_q!=0: cnt_load=1, cnt_value=dly_q, go to ARM.
  - If dly_q==0: no load, go straight to DONE.
- ARM: one blanking cycle; cnt_zero is ignored because it may still be stale from the previous run. Go to WAIT.
- WAIT: on cnt_zero=1 go to DONE.
- DONE: done[idx]=1 for exactly one cycle; pointer = (idx+1) mod NREQ; go to IDLE.
- Latency, delay D>0: req seen in IDLE at cycle 0 → LOAD at 1 → ARM at 2 → WAIT from 3 → done in the cycle after cnt_zero is sampled high.
- Latency, delay 0: done 2 cycles after IDLE.
- At least one IDLE cycle separates grants.
- Abort: if req[idx] drops during ARM or WAIT, return to IDLE with no done. The pointer still advances.
- req_delay changes after the grant are ignored; the value latched in IDLE is used.
- Simultaneous requests: round-robin is strictly fair. With all bits set, grant order is 0,1,…,NREQ-1,0.
- Arithmetic: no arithmetic in the base design (the watchdog adds its own, below).

Optional Feature:
- Macro: CNTCLK_SCHED_WDOG_EN.
- Defined:
  - A cycle counter of WIDTH+1 bits clears in ARM and increments in WAIT.
  - If it reaches dly_q + WDOG_MARGIN (computed at WIDTH+1 bits, no overflow) before cnt_zero arrives: pulse err=1 and done[idx]=1 for one cycle, then go to IDLE.
  - If cnt_zero and the limit occur in the same cycle, cnt_zero wins and err stays 0.
- Undefined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package cntclk_pkg holds:
  - the state enum (sched_state_t: IDLE, LOAD, ARM, WAIT, DONE);
  - the default WIDTH constant;
  - the localparam for the index width, $clog2(NREQ).
- One natural sub-module: cntclk_rr_arb. It is a combinational round-robin picker taking req and the pointer, and returning a one-hot grant, an index and a valid flag. The FSM and datapath stay in cntclk_sched.

Test Plan:
- Single request: req=4'b0001, delay=3, counter model. Expect cnt_load for 1 cycle with cnt_value=3, done[0] 1 cycle after zero, gnt[0] high for 6 cycles total.
- All requesters: req=4'b1111, delays 2,4,1,3, held until done. Expect done order 0,1,2,3, then 0 again; one IDLE cycle between grants.
- Zero delay: req[2]=1 with delay=0. Expect no cnt_load and done[2] exactly 2 cycles after the IDLE sample.
- Stale zero: cnt_zero held high across the load, delay=5. Expect ARM to ignore it; done only after the counter reloads and reaches zero.
- Abort and reset: drop req[1] during WAIT, expect IDLE with no done and the next grant going to requester 2. Separately, pull rst_n low mid-WAIT and expect all outputs 0 on the next edge.
- With CNTCLK_SCHED_WDOG_EN, WDOG_MARGIN=16, delay=10, cnt_zero stuck low: expect err and done[idx] in the same cycle, 26 cycles after ARM, then IDLE.

Source files
------------

// File: rtl/cntclk_pkg.sv
// Shared types and default sizes for the cntclk scheduler slice.
package cntclk_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int CNT_NREQ_DEF  = 4;
  localparam int CNT_IDX_W     = $clog2(CNT_NREQ_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/cntclk_rr_arb.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module cntclk_rr_arb
  import cntclk_pkg::*;
#(
  parameter int NREQ  = CNT_NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= unsigned'(NREQ)) s = s - unsigned'(NREQ);
    return s[IDX_W-1:0];
  endfunction

  // Scan from the farthest slot back towards ptr so the nearest set bit wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, unsigned'(k))]) begin
        vld = 1'b1;
        idx = wrap_add(ptr, unsigned'(k));
      end
    end
    gnt = vld ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/cntclk_sched.sv
// Round-robin scheduler sharing one cntclk down-counter among NREQ requesters.
// Optional watchdog enabled by defining CNTCLK_SCHED_WDOG_EN.
module cntclk_sched
  import cntclk_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DEF,
  parameter int NREQ        = CNT_NREQ_DEF,
  parameter int WDOG_MARGIN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_delay,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_value,
  input  logic                  cnt_zero,
  output logic                  err
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || WDOG_MARGIN < 0) begin : g_bad_param
    $error("cntclk_sched: NREQ must be 2..8 and WDOG_MARGIN non-negative");
  end

  sched_state_t     state;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] dly_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic [WIDTH-1:0] arb_dly;
  logic [IDX_W-1:0] idx_inc;
  logic             req_held;
  logic             wd_fire;

  cntclk_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_comb begin
    arb_dly = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) arb_dly = req_delay[i*WIDTH +: WIDTH];
    end
  end

  assign idx_inc  = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
  assign req_held = req[idx_q];

`ifdef CNTCLK_SCHED_WDOG_EN
  logic [WIDTH:0] wd_q;
  logic [WIDTH:0] wd_limit;

  assign wd_limit = {1'b0, dly_q} + (WIDTH+1)'(WDOG_MARGIN);
  // Decided one cycle early so err/done land exactly wd_limit cycles after ARM.
  assign wd_fire  = ({1'b0, wd_q} + (WIDTH+2)'(2)) >= {1'b0, wd_limit};

  always_ff @(posedge clk) begin
    if (state == ARM)       wd_q <= '0;
    else if (state == WAIT) wd_q <= wd_q + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cnt_load  <= 1'b0;
      cnt_value <= '0;
      err       <= 1'b0;
    end else begin
      done      <= '0;
      err       <= 1'b0;
      cnt_load  <= 1'b0;
      cnt_value <= '0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            state     <= LOAD;
            idx_q     <= arb_idx;
            dly_q     <= arb_dly;
            gnt       <= arb_gnt;
            busy      <= 1'b1;
            cnt_load  <= (arb_dly != '0);
            cnt_value <= arb_dly;
          end
        end
        LOAD: begin
          if (dly_q == '0) begin
            state <= DONE;
            done  <= gnt;
          end else begin
            state <= ARM;
          end
        end
        // cnt_zero may still be stale from the previous run here.
        ARM: begin
          if (!req_held) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr_q <= idx_inc;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req_held) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr_q <= idx_inc;
          end else if (cnt_zero) begin
            state <= DONE;
            done  <= gnt;
          end else if (wd_fire) begin
            state <= DONE;
            done  <= gnt;
            err   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr_q <= idx_inc;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cntclk_sched.sv
// Bench for cntclk_sched: timeline reference model, directed and random stimulus.
module tb_cntclk_sched;

  localparam int W = 16;
  localparam int N = 4;
  localparam int MARGIN = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N*W-1:0] req_delay;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         busy;
  logic         cnt_load;
  logic [W-1:0] cnt_value;
  logic         cnt_zero;
  logic         err;

  logic [W-1:0] cnt = '0;
  bit           stuck_hi = 1'b0;
  bit           stuck_lo = 1'b0;

  int tests = 0;
  int fails = 0;

  cntclk_sched #(
    .WIDTH       (W),
    .NREQ        (N),
    .WDOG_MARGIN (MARGIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_delay (req_delay),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt_load  (cnt_load),
    .cnt_value (cnt_value),
    .cnt_zero  (cnt_zero),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared loadable down-counter the scheduler drives.
  always @(posedge clk) begin
    if (cnt_load)       cnt <= cnt_value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign cnt_zero = stuck_lo ? 1'b0 : (stuck_hi | (cnt == '0));

  // Reference model: one transaction at a time, outputs derived from its
  // cycle offset relative to the IDLE cycle in which it was picked.
  bit     chk_en = 1'b0;
  int     cyc = 0;
  bit     m_act = 1'b0;
  int     m_idx, m_t0, m_d, m_fin, m_err_at, m_ptr, mj, rel;
  logic [N-1:0] e_gnt, e_done;
  logic   e_busy, e_load, e_err;
  logic [W-1:0] e_val;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; m_ptr = 0; m_err_at = -1; m_fin = -1; chk_en = 1'b1;
    end else if (!m_act) begin
      for (int k = 0; k < N; k++) begin
        mj = (m_ptr + k) % N;
        if (!m_act && req[mj]) begin
          m_act = 1'b1; m_idx = mj; m_t0 = cyc;
          m_d = int'(req_delay[mj*W +: W]); m_fin = -1; m_err_at = -1;
        end
      end
    end else begin
      rel = cyc - m_t0;
      if (m_d == 0) begin
        if (rel == 2) begin m_act = 1'b0; m_ptr = (m_idx + 1) % N; end
      end else if (m_fin >= 0 && cyc == m_fin) begin
        m_act = 1'b0; m_ptr = (m_idx + 1) % N;
      end else if (rel >= 2 && !req[m_idx]) begin
        m_act = 1'b0; m_ptr = (m_idx + 1) % N;
      end else if (rel >= 3) begin
        if (cnt_zero) m_fin = cyc + 1;
`ifdef CNTCLK_SCHED_WDOG_EN
        else if ((cyc + 1) - (m_t0 + 2) >= m_d + MARGIN) begin
          m_fin = cyc + 1; m_err_at = cyc + 1;
        end
`endif
      end
    end
    cyc = cyc + 1;
    rel = cyc - m_t0;
    e_gnt  = (m_act && rel >= 1) ? (N'(1) << m_idx) : '0;
    e_busy = m_act && rel >= 1;
    e_load = m_act && rel == 1 && m_d != 0;
    e_val  = e_load ? W'(m_d) : '0;
    e_done = (m_act && ((m_d == 0 && rel == 2) || (m_d != 0 && cyc == m_fin))) ?
             (N'(1) << m_idx) : '0;
    e_err  = m_act && (cyc == m_err_at);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({gnt, done, busy, cnt_load, cnt_value, err} !==
          {e_gnt, e_done, e_busy, e_load, e_val, e_err}) begin
        fails++;
        $display("FAIL cycle_%0d outputs: got gnt=%b done=%b busy=%b load=%b value=%0d err=%b, expected gnt=%b done=%b busy=%b load=%b value=%0d err=%b",
                 cyc, gnt, done, busy, cnt_load, cnt_value, err,
                 e_gnt, e_done, e_busy, e_load, e_val, e_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int gcnt, nload, lv, dt, got_err;
  bit got;
  int order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; req = '0; req_delay = '0;
    tick(); tick(); tick();
    check("reset_outputs", {gnt, done, busy, cnt_load, cnt_value, err}, 0);
    rst_n = 1'b1;
    tick();

    // Single request, delay 3.
    req_delay[0*W +: W] = 16'd3; req = 4'b0001;
    gcnt = 0; nload = 0; lv = 0; got = 1'b0; dt = 0;
    for (int t = 1; t <= 40 && !got; t++) begin
      tick();
      if (gnt[0]) gcnt++;
      if (cnt_load) begin nload++; lv = int'(cnt_value); end
      if (done[0]) begin got = 1'b1; dt = t; end
    end
    req = '0;
    check("single_done_seen", got, 1);
    check("single_gnt_cycles", gcnt, 6);
    check("single_loads", nload, 1);
    check("single_load_value", lv, 3);
    check("single_done_tick", dt, 6);
    tick();

    // All requesters from pointer 0.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req_delay = {16'd3, 16'd1, 16'd4, 16'd2}; req = 4'b1111;
    order.delete();
    for (int t = 0; t < 300 && order.size() < 5; t++) begin
      tick();
      for (int i = 0; i < N; i++) if (done[i]) order.push_back(i);
    end
    req = '0;
    check("all_done_count", order.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("all_order_%0d", k), (k < order.size()) ? order[k] : 99, exp_order[k]);
    tick();

    // Zero delay on requester 2.
    req_delay = '0; req = 4'b0100;
    got = 1'b0; dt = 0; nload = 0;
    for (int t = 1; t <= 10 && !got; t++) begin
      tick();
      if (cnt_load) nload++;
      if (done[2]) begin got = 1'b1; dt = t; end
    end
    req = '0;
    check("zero_done_tick", dt, 2);
    check("zero_no_load", nload, 0);
    tick();

    // Stale zero held high through LOAD and ARM.
    req_delay[0*W +: W] = 16'd5; req = 4'b0001; stuck_hi = 1'b1;
    tick(); tick(); tick();
    stuck_hi = 1'b0;
    got = 1'b0; dt = 3;
    for (int t = 4; t <= 30 && !got; t++) begin
      tick();
      if (done[0]) begin got = 1'b1; dt = t; end
    end
    req = '0;
    check("stale_done_tick", dt, 8);
    tick();

    // Abort requester 1 in WAIT; requester 2 is next.
    req_delay = '0; req_delay[1*W +: W] = 16'd20; req_delay[2*W +: W] = 16'd1;
    req = 4'b0110;
    for (int t = 0; t < 5; t++) tick();
    check("abort_gnt_before", gnt, 4'b0010);
    req = 4'b0100;
    tick();
    check("abort_idle_busy", busy, 0);
    check("abort_no_done", done, 0);
    tick();
    check("abort_next_gnt", gnt, 4'b0100);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (done[2]) got = 1'b1;
    end
    req = '0;
    check("abort_next_done", got, 1);
    tick();

    // Reset in the middle of WAIT.
    req_delay[3*W +: W] = 16'd30; req = 4'b1000;
    for (int t = 0; t < 5; t++) tick();
    check("rst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs", {gnt, done, busy, cnt_load, cnt_value, err}, 0);
    rst_n = 1'b1; req = '0;
    tick();

`ifdef CNTCLK_SCHED_WDOG_EN
    // Watchdog: counter never reports zero.
    stuck_lo = 1'b1; req_delay = '0; req_delay[0*W +: W] = 16'd10; req = 4'b0001;
    got = 1'b0; dt = 0; got_err = 0;
    for (int t = 1; t <= 60 && !got; t++) begin
      tick();
      if (done[0]) begin got = 1'b1; dt = t; got_err = int'(err); end
    end
    req = '0;
    check("wdog_done_tick", dt, 28);
    check("wdog_err_with_done", got_err, 1);
    tick();
    check("wdog_back_idle", busy, 0);
    stuck_lo = 1'b0;
    tick();
`endif

    // Randomised traffic; delays are re-randomised every cycle.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && done[i])                       req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 299) == 0) req[i] = 1'b0;
        req_delay[i*W +: W] = W'($urandom_range(0, 9));
      end
      stuck_hi = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    stuck_hi = 1'b0; rst_n = 1'b1; req = '0;
    for (int t = 0; t < 30; t++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
